button_scheduler: RTL
=====================

# button_scheduler

Sequences raw switch/button activity into single, debounced key events for the calculator core. Sits between the board-level `switches_i` pins and the calculator's button-decode path, clocked by the 100 MHz clock and paced by a 1 kHz enable. Enforces one-press-at-a-time: a press is accepted only when exactly one button is held. It emits exactly one valid/ready event per press, then locks out until the button is released.

## Interface
- `NUM_BUTTONS`, 16: width of the button vector. The index fits `calc_pkg::active_button_t`.
- `DEBOUNCE_TICKS`, 4: consecutive stable `tick_i` samples required for both press and release. Must be >= 1.
- `clk_i` input 1: single clock, 100 MHz.
- `rst_i` input 1: reset, asynchronous, active-high.
- `tick_i` input 1: one-cycle sample enable at 1 kHz.
- `buttons_i` input NUM_BUTTONS: raw, asynchronous button levels.
- `ready_i` input 1: the calculator core accepts the event.
- `valid_o` output 1: a key event is pending.
- `button_o` output `calc_pkg::active_button_t`: index of the pressed button. Stable while `valid_o` is high.
- `multi_o` output 1: the last tick sample had two or more buttons set.

## Operation
- **Synchronizer:** `buttons_i` passes through 2 flops, reset to 0. Only the value `s` (synchronized) at a `tick_i` cycle is used.
- **IDLE**
  - On a tick with `s` one-hot: latch its index into `button_o`, set cnt=1, go to DEBOUNCE.
  - If `DEBOUNCE_TICKS`==1, go directly to PRESS.
  - Otherwise stay in IDLE.
- **DEBOUNCE**
  - On a tick with `s` equal to the one-hot of the latched index: cnt++. When cnt reaches `DEBOUNCE_TICKS`, go to PRESS.
  - On a tick with any other `s` (zero, a different button, or multi): cnt=0, go to IDLE. No event is emitted. A different single button restarts from IDLE on a later tick.
- **PRESS**
  - `valid_o`=1.
  - On `valid_o && ready_i`: cnt=0, go to RELEASE.
  - Ticks and input changes are ignored. `button_o` is frozen.
- **RELEASE**
  - On a tick with `s`==0: cnt++. Otherwise cnt=0.
  - When cnt reaches `DEBOUNCE_TICKS`, go to IDLE.
  - Holding the same button, or adding buttons, never produces a second event.
- **multi_o:** registered on every tick as (popcount(`s`) >= 2), in all states. It holds between ticks.
- **Counter width:** `$clog2(DEBOUNCE_TICKS+1)`. The counter saturates and never wraps.

## Timing
- Reset values: state=IDLE, cnt=0, `valid_o`=0, `button_o`=0, `multi_o`=0, synchronizer flops=0. Reset mid-operation drops any pending event immediately (asynchronous).
- Input-to-sample latency: 2 cycles. A change must be present 2 cycles before a tick to be seen at that tick.
- Press latency: `valid_o` rises the cycle after the `DEBOUNCE_TICKS`-th consecutive matching tick.
- Handshake:
  - `valid_o` holds until the cycle `ready_i` is high.
  - If `ready_i` is already high when `valid_o` rises, the transfer completes in that first cycle and `valid_o` is high for exactly 1 cycle.
  - `valid_o` never depends combinationally on `ready_i`.
- Simultaneous events:
  - A `tick_i` in the same cycle as the handshake is ignored; RELEASE counting starts at the next tick.
  - `tick_i` high for consecutive cycles counts each cycle as a sample.
- Minimum spacing between two events: `DEBOUNCE_TICKS` release ticks plus `DEBOUNCE_TICKS` press ticks.

## Structure
- In `calc_pkg`, add `button_sched_state_e` (IDLE, DEBOUNCE, PRESS, RELEASE). Reuse the existing `active_button_t` for `button_o`.
- One sub-module, `button_sync`: a parameterized-width 2-flop synchronizer with asynchronous active-high reset.
- One-hot detection and index encoding are local combinational logic. No further sub-modules.

## Test plan
Bench settings: `DEBOUNCE_TICKS`=4, tick every 100 cycles, `ready_i`=1 unless noted.
- **Clean press:** `buttons_i`=16'h0020 held 10 ticks → `valid_o` high 1 cycle after the 4th tick, `button_o`=5, exactly one event. Release for 4 ticks → back in IDLE.
- **Bounce:** `buttons_i`=16'h0100 for 2 ticks, then 0 for 1 tick, then 16'h0100 for 4 ticks → no event during the first burst; one event with `button_o`=8 after the final 4 ticks.
- **Two buttons:** `buttons_i`=16'h8001 for 8 ticks → `valid_o` never rises. `multi_o`=1 from the first tick; it clears on the first tick after the vector returns to 16'h0001.
- **Backpressure:** `ready_i`=0, press button 3 → `valid_o` and `button_o`=3 held for 500 cycles while `buttons_i` changes to 16'h0010. Raise `ready_i` → `valid_o` drops the next cycle; no event for button 4 until a release is seen.
- **Held key:** button 12 held 50 ticks → exactly one event.
- **Reset mid-PRESS:** assert `rst_i` while `valid_o`=1 → `valid_o`=0 and `button_o`=0 asynchronously. After release of `rst_i` with the button still held, a new event appears after 4 ticks.

Source files
------------

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared types for the calculator datapath and its front-end blocks.
//   active_button_t      : index of a single pressed button (16 buttons)
//   button_sched_state_e : state of the button_scheduler sequencer
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam int CALC_NUM_BUTTONS = 16;

    typedef logic [$clog2(CALC_NUM_BUTTONS)-1:0] active_button_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESS    = 2'd2,
        RELEASE  = 2'd3
    } button_sched_state_e;

endpackage : calc_pkg

// File: rtl/button_sync.sv
// ---------------------------------------------------------------------------
// button_sync
// Two-flop synchronizer for a vector of asynchronous levels.
// Ports:
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears both stages to 0
//   d_i   : raw asynchronous input vector
//   q_o   : synchronized vector, 2 cycles behind d_i
// ---------------------------------------------------------------------------
module button_sync #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back capture stages; first stage may go metastable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule : button_sync

// File: rtl/button_scheduler.sv
// ---------------------------------------------------------------------------
// button_scheduler
// Turns raw button levels into single debounced key events with a
// valid/ready handshake. Only one button at a time is accepted; after an
// event the block waits for a debounced full release before arming again.
// Ports:
//   clk_i     : 100 MHz clock
//   rst_i     : asynchronous active-high reset
//   tick_i    : one-cycle 1 kHz sample enable
//   buttons_i : raw asynchronous button levels
//   ready_i   : calculator core accepts the pending event
//   valid_o   : a key event is pending (registered)
//   button_o  : index of the pressed button, frozen while valid_o is high
//   multi_o   : last tick sample had two or more buttons set
// ---------------------------------------------------------------------------
module button_scheduler
    import calc_pkg::*;
#(
    parameter int NUM_BUTTONS    = 16,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tick_i,
    input  logic [NUM_BUTTONS-1:0] buttons_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output active_button_t         button_o,
    output logic                   multi_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);
    localparam logic [NUM_BUTTONS-1:0] ONE_VEC = NUM_BUTTONS'(1);

    button_sched_state_e    r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_valid;
    active_button_t         r_button;
    logic                   r_multi;

    logic [NUM_BUTTONS-1:0] w_sync;
    logic [NUM_BUTTONS-1:0] w_low_bits;
    logic                   w_nonzero;
    logic                   w_one_hot;
    logic                   w_multi;
    logic                   w_match;
    active_button_t         w_index;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   w_cnt_done;

    button_sync #(
        .WIDTH (NUM_BUTTONS)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (buttons_i),
        .q_o   (w_sync)
    );

    // s & (s-1) clears the lowest set bit: anything left means >= 2 bits set.
    assign w_low_bits = w_sync & (w_sync - ONE_VEC);
    assign w_nonzero  = |w_sync;
    assign w_multi    = |w_low_bits;
    assign w_one_hot  = w_nonzero & ~w_multi;
    assign w_match    = (w_sync == (ONE_VEC << r_button));

    // Saturating increment so the counter can never wrap back to zero.
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);
    assign w_cnt_done = (w_cnt_inc == CNT_MAX);

    // Encode the index of the set bit; only meaningful when w_one_hot.
    always_comb begin
        w_index = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            w_index = w_sync[i] ? active_button_t'(i) : w_index;
        end
    end

    // Press/release sequencer with registered valid and button outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_button <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (tick_i && w_one_hot) begin
                        r_button <= w_index;
                        r_cnt    <= CNT_ONE;
                        if (CNT_ONE == CNT_MAX) begin
                            r_state <= PRESS;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (tick_i) begin
                        if (w_match) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_done) begin
                                r_state <= PRESS;
                                r_valid <= 1'b1;
                            end
                        end else begin
                            // Any disturbance abandons the candidate; the
                            // disturbing sample itself is not reused.
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end
                    end
                end
                PRESS: begin
                    // Ticks are ignored here, including one coincident
                    // with the handshake.
                    if (r_valid && ready_i) begin
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (tick_i) begin
                        if (!w_nonzero) begin
                            if (w_cnt_done) begin
                                r_cnt   <= '0;
                                r_state <= IDLE;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Multi-press flag: refreshed on every tick regardless of state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_multi <= 1'b0;
        end else if (tick_i) begin
            r_multi <= w_multi;
        end else begin
            r_multi <= r_multi;
        end
    end

    assign valid_o  = r_valid;
    assign button_o = r_button;
    assign multi_o  = r_multi;

endmodule : button_scheduler
